// File: rtl/imm_pkg.sv
// Shared immediate-class enum and opcode constants for the OTTER decode path.
// Also imported by the ID/EX consumers.
package imm_pkg;

   typedef enum logic [2:0] {
      ImmNone = 3'd0,
      ImmI    = 3'd1,
      ImmS    = 3'd2,
      ImmB    = 3'd3,
      ImmU    = 3'd4,
      ImmJ    = 3'd5,
      ImmZ    = 3'd6
   } imm_type_e;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpImm32  = 7'b0011011;
   localparam logic [6:0] OpSystem = 7'b1110011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode classifier and sign-extended immediate builder.
// IMMGEN_ZICSR_EN enables class Z for CSR-immediate instructions.
module imm_extract
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     i_ir,
   output imm_type_e       o_type,
   output logic [XLEN-1:0] o_imm
);

   logic [6:0]  w_opcode;
   logic [31:0] w_imm32;

   assign w_opcode = i_ir[6:0];

   always_comb begin
      o_type  = ImmNone;
      w_imm32 = '0;
      case (w_opcode)
         OpLui, OpAuipc: begin
            o_type  = ImmU;
            w_imm32 = {i_ir[31:12], 12'b0};
         end
         OpJal: begin
            o_type  = ImmJ;
            w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
         end
         OpJalr, OpLoad, OpImm, OpImm32: begin
            o_type  = ImmI;
            w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
         end
         OpSystem: begin
`ifdef IMMGEN_ZICSR_EN
            if (i_ir[14]) begin
               o_type  = ImmZ;
               w_imm32 = {27'b0, i_ir[19:15]};
            end else begin
               o_type  = ImmI;
               w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
            end
`else
            o_type  = ImmI;
            w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
`endif
         end
         OpStore: begin
            o_type  = ImmS;
            w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
         end
         OpBranch: begin
            o_type  = ImmB;
            w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
         end
         default: begin
            o_type  = ImmNone;
            w_imm32 = '0;
         end
      endcase
   end

   // Every class is formed at 32 bits; Z has bit 31 clear, so one sign extension covers all.
   assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_decode_pipe.sv
// Two-stage immediate decoder: stage 1 registers class/imm/pc, stage 2 adds the target.
// Valid/ready backpressure with flush; CSR immediates gated by IMMGEN_ZICSR_EN.
module imm_decode_pipe
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_ir,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output imm_type_e       out_type,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_pc
);

   imm_type_e       w_type;
   logic [XLEN-1:0] w_imm;
   logic            w_adv2;
   logic            w_accept;
   logic            w_move;

   logic            r_s1_v;
   imm_type_e       r_s1_type;
   logic [XLEN-1:0] r_s1_imm;
   logic [XLEN-1:0] r_s1_pc;

   logic            r_s2_v;
   imm_type_e       r_s2_type;
   logic [XLEN-1:0] r_s2_imm;
   logic [XLEN-1:0] r_s2_pc;
   logic [XLEN-1:0] r_s2_target;

   imm_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .i_ir   (in_ir),
      .o_type (w_type),
      .o_imm  (w_imm)
   );

   assign w_adv2   = !r_s2_v || out_ready;
   assign in_ready = (!r_s1_v || w_adv2) && !flush;
   assign w_accept = in_valid && in_ready;
   assign w_move   = r_s1_v && w_adv2;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1_v    <= 1'b0;
         r_s1_type <= ImmNone;
         r_s1_imm  <= '0;
         r_s1_pc   <= '0;
      end else if (flush) begin
         r_s1_v <= 1'b0;
      end else if (w_accept) begin
         r_s1_v    <= 1'b1;
         r_s1_type <= w_type;
         r_s1_imm  <= w_imm;
         r_s1_pc   <= in_pc;
      end else if (w_move) begin
         r_s1_v <= 1'b0;
      end
   end

   // Target is formed from stage-1 registers so the adder sits off the input path.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s2_v      <= 1'b0;
         r_s2_type   <= ImmNone;
         r_s2_imm    <= '0;
         r_s2_pc     <= '0;
         r_s2_target <= '0;
      end else if (flush) begin
         r_s2_v <= 1'b0;
      end else if (w_move) begin
         r_s2_v      <= 1'b1;
         r_s2_type   <= r_s1_type;
         r_s2_imm    <= r_s1_imm;
         r_s2_pc     <= r_s1_pc;
         r_s2_target <= r_s1_pc + r_s1_imm;
      end else if (out_ready) begin
         r_s2_v <= 1'b0;
      end
   end

   assign out_valid  = r_s2_v;
   assign out_type   = r_s2_type;
   assign out_imm    = r_s2_imm;
   assign out_target = r_s2_target;
   assign out_pc     = r_s2_pc;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_imm_decode_pipe;
   import imm_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        flush;
   logic        out_ready;
   logic [31:0] ir;
   logic [31:0] pc;
   logic [63:0] pc64;

   logic        rdy32, vld32;
   imm_type_e   t32;
   logic [31:0] imm32, tgt32, opc32;
   logic        rdy64, vld64;
   imm_type_e   t64;
   logic [63:0] imm64, tgt64, opc64;

   int n_cmp  = 0;
   int n_fail = 0;

   assign pc64 = {32'b0, pc};

   imm_decode_pipe #(.XLEN(32)) dut32 (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(rdy32), .in_ir(ir), .in_pc(pc),
      .flush(flush), .out_valid(vld32), .out_ready(out_ready), .out_type(t32),
      .out_imm(imm32), .out_target(tgt32), .out_pc(opc32)
   );

   imm_decode_pipe #(.XLEN(64)) dut64 (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(rdy64), .in_ir(ir), .in_pc(pc64),
      .flush(flush), .out_valid(vld64), .out_ready(out_ready), .out_type(t64),
      .out_imm(imm64), .out_target(tgt64), .out_pc(opc64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ir_w, input logic [31:0] pc_w);
      in_valid = v;
      ir       = ir_w;
      pc       = pc_w;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", vld32); end
      n_cmp++; if (t32 !== ImmNone) begin n_fail++; $display("FAIL reset_type got %0d exp 0", t32); end
      n_cmp++; if (imm32 !== 32'h0 || tgt32 !== 32'h0 || opc32 !== 32'h0) begin
         n_fail++; $display("FAIL reset_data got %h/%h/%h exp 0", imm32, tgt32, opc32);
      end
      n_cmp++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", rdy32); end
   endtask

   task automatic test_jal();
      drive(1'b1, 32'h0080006F, 32'h100);
      #1;
      n_cmp++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL jal_in_ready got %b exp 1", rdy32); end
      tick();
      drive(1'b0, 32'h0, 32'h0);
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL jal_early got %b exp 0", vld32); end
      tick();
      n_cmp++; if (vld32 !== 1'b1) begin n_fail++; $display("FAIL jal_valid got %b exp 1", vld32); end
      n_cmp++; if (t32 !== ImmJ) begin n_fail++; $display("FAIL jal_type got %0d exp 5", t32); end
      n_cmp++; if (imm32 !== 32'h8) begin n_fail++; $display("FAIL jal_imm got %h exp 8", imm32); end
      n_cmp++; if (tgt32 !== 32'h108) begin n_fail++; $display("FAIL jal_target got %h exp 108", tgt32); end
      n_cmp++; if (opc32 !== 32'h100) begin n_fail++; $display("FAIL jal_pc got %h exp 100", opc32); end
      tick();
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL jal_drain got %b exp 0", vld32); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(1'b1, 32'hFE000EE3, 32'h200);
      tick();
      drive(1'b1, 32'hFE000EE3, 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      n_cmp++; if (vld32 !== 1'b1 || t32 !== ImmB || opc32 !== 32'h200) begin
         n_fail++; $display("FAIL beq1_hdr got %b/%0d/%h exp 1/3/200", vld32, t32, opc32);
      end
      n_cmp++; if (imm32 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq1_imm got %h exp fffffffc", imm32); end
      n_cmp++; if (tgt32 !== 32'h1FC) begin n_fail++; $display("FAIL beq1_target got %h exp 1fc", tgt32); end
      tick();
      n_cmp++; if (vld32 !== 1'b1 || opc32 !== 32'h0) begin
         n_fail++; $display("FAIL beq2_hdr got %b/%h exp 1/0", vld32, opc32);
      end
      n_cmp++; if (tgt32 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq2_wrap got %h exp fffffffc", tgt32); end
      tick();
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL beq_drain got %b exp 0", vld32); end
   endtask

   task automatic test_classes();
      logic [31:0] v_ir  [4] = '{32'hFFF00093, 32'hFE20AC23, 32'h12345097, 32'h002081B3};
      imm_type_e   v_typ [4] = '{ImmI, ImmS, ImmU, ImmNone};
      logic [31:0] v_imm [4] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'h12345000, 32'h0};
      logic [31:0] v_tgt [4] = '{32'h2FF, 32'h2F8, 32'h12345300, 32'h300};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, v_ir[k], 32'h300);
         tick();
         drive(1'b0, 32'h0, 32'h0);
         tick();
         n_cmp++; if (vld32 !== 1'b1 || t32 !== v_typ[k]) begin
            n_fail++; $display("FAIL class%0d_type got %b/%0d exp 1/%0d", k, vld32, t32, v_typ[k]);
         end
         n_cmp++; if (imm32 !== v_imm[k] || tgt32 !== v_tgt[k]) begin
            n_fail++; $display("FAIL class%0d_imm got %h/%h exp %h/%h", k, imm32, tgt32, v_imm[k], v_tgt[k]);
         end
      end
      tick();
   endtask

   task automatic test_lui64();
      out_ready = 1'b1;
      drive(1'b1, 32'h800002B7, 32'h1000);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tick();
      n_cmp++; if (vld64 !== 1'b1 || t64 !== ImmU) begin
         n_fail++; $display("FAIL lui64_type got %b/%0d exp 1/4", vld64, t64);
      end
      n_cmp++; if (imm64 !== 64'hFFFFFFFF80000000) begin
         n_fail++; $display("FAIL lui64_imm got %h exp ffffffff80000000", imm64);
      end
      n_cmp++; if (tgt64 !== 64'hFFFFFFFF80001000) begin
         n_fail++; $display("FAIL lui64_target got %h exp ffffffff80001000", tgt64);
      end
      n_cmp++; if (imm32 !== 32'h80000000 || tgt32 !== 32'h80001000) begin
         n_fail++; $display("FAIL lui32 got %h/%h exp 80000000/80001000", imm32, tgt32);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] bp_ir [3] = '{32'h00100093, 32'h00200093, 32'h00300093};
      int sent  = 0;
      int rcvd  = 0;
      int third = -1;
      for (int c = 0; c < 12; c++) begin
         out_ready = (c >= 4);
         if (sent < 3) drive(1'b1, bp_ir[sent], 32'(32'h10 + 4 * sent));
         else drive(1'b0, 32'h0, 32'h0);
         #1;
         if (c == 1) begin
            n_cmp++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_c1 got %b exp 1", rdy32); end
         end
         if (c == 2 || c == 3) begin
            n_cmp++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c%0d got %b exp 0", c, rdy32); end
            n_cmp++; if (vld32 !== 1'b1 || opc32 !== 32'h10) begin
               n_fail++; $display("FAIL bp_hold_c%0d got %b/%h exp 1/10", c, vld32, opc32);
            end
         end
         if (in_valid && rdy32) begin
            if (sent == 2) third = c;
            sent++;
         end
         if (vld32 && out_ready) begin
            n_cmp++; if (rcvd >= 3 || opc32 !== 32'(32'h10 + 4 * rcvd) || imm32 !== 32'(rcvd + 1)) begin
               n_fail++; $display("FAIL bp_order%0d got %h/%h exp %h/%h", rcvd, opc32, imm32,
                                  32'(32'h10 + 4 * rcvd), 32'(rcvd + 1));
            end
            rcvd++;
         end
         tick();
      end
      n_cmp++; if (third !== 4) begin n_fail++; $display("FAIL bp_third_accept got %0d exp 4", third); end
      n_cmp++; if (rcvd !== 3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", rcvd); end
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", vld32); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h40);
      tick();
      drive(1'b1, 32'h00200093, 32'h44);
      tick();
      n_cmp++; if (vld32 !== 1'b1 || rdy32 !== 1'b0) begin
         n_fail++; $display("FAIL fl_full got %b/%b exp 1/0", vld32, rdy32);
      end
      flush = 1'b1;
      drive(1'b1, 32'h00700093, 32'h99C);
      #1;
      n_cmp++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready got %b exp 0", rdy32); end
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b exp 0", vld32); end
      #1;
      n_cmp++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL fl_empty_ready got %b exp 1", rdy32); end
      out_ready = 1'b1;
      drive(1'b1, 32'h00500093, 32'h80);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      n_cmp++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL fl_next_early got %b exp 0", vld32); end
      tick();
      n_cmp++; if (vld32 !== 1'b1 || opc32 !== 32'h80 || imm32 !== 32'h5) begin
         n_fail++; $display("FAIL fl_next got %b/%h/%h exp 1/80/5", vld32, opc32, imm32);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++; if (vld32 !== 1'b0) begin
            n_fail++; $display("FAIL fl_ghost%0d got %b pc %h exp 0", c, vld32, opc32);
         end
      end
   endtask

   task automatic test_csr();
      out_ready = 1'b1;
      drive(1'b1, 32'h3008D073, 32'h400);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tick();
`ifdef IMMGEN_ZICSR_EN
      n_cmp++; if (vld32 !== 1'b1 || t32 !== ImmZ) begin
         n_fail++; $display("FAIL csr_type got %b/%0d exp 1/6", vld32, t32);
      end
      n_cmp++; if (imm32 !== 32'd17 || tgt32 !== 32'h411) begin
         n_fail++; $display("FAIL csr_imm got %h/%h exp 11/411", imm32, tgt32);
      end
      n_cmp++; if (imm64 !== 64'd17) begin n_fail++; $display("FAIL csr_imm64 got %h exp 11", imm64); end
`else
      n_cmp++; if (vld32 !== 1'b1 || t32 !== ImmI) begin
         n_fail++; $display("FAIL csr_type got %b/%0d exp 1/1", vld32, t32);
      end
      n_cmp++; if (imm32 !== 32'h300 || tgt32 !== 32'h700) begin
         n_fail++; $display("FAIL csr_imm got %h/%h exp 300/700", imm32, tgt32);
      end
      n_cmp++; if (imm64 !== 64'h300) begin n_fail++; $display("FAIL csr_imm64 got %h exp 300", imm64); end
`endif
      tick();
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 32'h500);
      tick();
      drive(1'b1, 32'hFE000EE3, 32'h504);
      tick();
      rst = 1'b1;
      drive(1'b1, 32'h0080006F, 32'h508);
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      n_cmp++; if (vld32 !== 1'b0 || t32 !== ImmNone) begin
         n_fail++; $display("FAIL rstm_hdr got %b/%0d exp 0/0", vld32, t32);
      end
      n_cmp++; if (imm32 !== 32'h0 || tgt32 !== 32'h0 || opc32 !== 32'h0) begin
         n_fail++; $display("FAIL rstm_data got %h/%h/%h exp 0", imm32, tgt32, opc32);
      end
      n_cmp++; if (vld64 !== 1'b0 || imm64 !== 64'h0 || tgt64 !== 64'h0 || opc64 !== 64'h0) begin
         n_fail++; $display("FAIL rstm_data64 got %b/%h/%h/%h exp 0", vld64, imm64, tgt64, opc64);
      end
      tick();
      n_cmp++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
         n_fail++; $display("FAIL rstm_after got %b/%b exp 0/1", vld32, rdy32);
      end
   endtask

   initial begin
      test_reset();
      test_jal();
      test_back_to_back();
      test_classes();
      test_lui64();
      test_backpressure();
      test_flush();
      test_csr();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Parametrised, pipelined immediate decoder for the OTTER decode stage. It classifies each instruction by opcode, builds the sign-extended immediate at XLEN width, and computes `pc + imm` as a target. Results pass through two registered stages with valid/ready backpressure and a flush, so the block sits directly between fetch/decode and the ID/EX register.

## Interface

**Parameters**
- `XLEN`, default 32: datapath width. Legal values are 32 and 64.

**Ports**
- `CLK`, in, 1: system clock. All state updates on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_ir` and `in_pc` are valid.
- `in_ready`, out, 1: the block accepts the input this cycle.
- `in_ir`, in, 32: instruction word.
- `in_pc`, in, XLEN: address of the instruction.
- `flush`, in, 1: discard all in-flight entries.
- `out_valid`, out, 1: the stage-2 result is valid.
- `out_ready`, in, 1: the consumer takes the result this cycle.
- `out_type`, out, 3: immediate class (`imm_type_e`).
- `out_imm`, out, XLEN: sign-extended immediate.
- `out_target`, out, XLEN: `pc + imm`.
- `out_pc`, out, XLEN: the instruction's pc, passed through.

## Operation

**Opcode classification** (`ir[6:0]`):
- 0110111 and 0010111 map to U.
- 1101111 maps to J.
- 1100111, 0000011, 0010011, 0011011 and 1110011 map to I.
- 0100011 maps to S.
- 1100011 maps to B.
- Any other opcode maps to NONE, with imm = 0.

**Immediate construction** (all sign extension uses `ir[31]` up to XLEN):
- I: `ir[31:20]`.
- S: `{ir[31:25], ir[11:7]}`.
- B: `{ir[31], ir[7], ir[30:25], ir[11:8], 0}`.
- U: `{ir[31:12], 12'b0}`. On XLEN=64 this is sign-extended from bit 31.
- J: `{ir[31], ir[19:12], ir[20], ir[30:21], 0}`.

**Target:** `in_pc + imm`, truncated modulo 2^XLEN. Overflow wraps and no flag is raised. The target is computed for every class, and consumers ignore it where it is meaningless (e.g. JALR, LOAD).

**Pipeline**
- Occupancy bits are `s1_v` and `s2_v`.
- `adv2 = !s2_v || out_ready`.
- `in_ready = (!s1_v || adv2) && !flush`.
- Stage 1 registers the class, imm and pc on `in_valid && in_ready`.
- Stage 2 loads from stage 1 when `s1_v && adv2`; it computes the target from the registered stage-1 values.
- `out_valid = s2_v`. Outputs hold stable while `out_valid && !out_ready`.
- Order is strictly preserved and nothing is dropped under backpressure.

**Flush**
- On `flush` at edge N, `s1_v` and `s2_v` are 0 after edge N.
- An input presented in the same cycle is not accepted (`in_ready` = 0).
- Flush takes priority over all advance and load conditions.

**Reset:** `RST` at an edge clears `s1_v` and `s2_v` and zeroes every data register. This applies even mid-stream. After reset, all outputs are 0 and `out_type` = NONE.

## Timing

- **Latency:** an input accepted at edge N appears with `out_valid` = 1 after edge N+1, when there is no stall.
- **Throughput:** one instruction per cycle while `out_ready` = 1.
- **Capacity:** two entries. With `out_ready` held low, `in_ready` falls after the second accept.
- `in_ready` depends combinationally on `out_ready` and `flush`. No other input-to-output combinational path exists.

## Configuration

Macro `IMMGEN_ZICSR_EN` controls CSR-immediate decoding.

- **Defined:**
  - Opcode 1110011 with `ir[14]` = 1 (CSRRWI/CSRRSI/CSRRCI) maps to class Z.
  - The imm is the 5-bit zero-extended `ir[19:15]`.
  - The target is still `pc + imm`.
- **Undefined:** class Z is never produced, and these opcodes decode as I. The enum value is reserved either way.

## Structure

- **`imm_pkg`** holds:
  - `imm_type_e` (NONE, I, S, B, U, J, Z).
  - The `localparam` opcode constants.
  - The ID/EX consumers import it.
- **`imm_extract`** is a combinational sub-module used by stage 1. It takes `ir` and returns type and imm, is parametrised by XLEN, and contains the `IMMGEN_ZICSR_EN` branch.

## Test plan

- **JAL:** XLEN=32, IR 0x0080006F, pc 0x100 → two cycles later type J, imm 0x8, target 0x108, pc 0x100.
- **BEQ, negative offset:** IR 0xFE000EE3, pc 0x200 → type B, imm 0xFFFFFFFC, target 0x1FC. With pc 0x0 the target wraps to 0xFFFFFFFC.
- **LUI on XLEN=64:** IR 0x800002B7 → type U, imm 0xFFFFFFFF80000000.
- **Backpressure:** send 3 instructions back-to-back with `out_ready` low for 4 cycles. Required response:
  - `in_ready` drops after 2 accepts.
  - Third accept occurs only after `out_ready` rises.
  - All 3 emerge in order with no duplicates.
- **Flush:** assert `flush` with both stages full and `in_valid` high. Required response:
  - `out_valid` = 0 next cycle.
  - The flushed-cycle input never appears.
  - Next accepted instruction emerges 2 cycles later.
- **CSR immediate:** IR 0x3008D073 (csrrwi x0, 0x300, 17):
  - With `IMMGEN_ZICSR_EN`: type Z, imm 17.
  - Without it: type I, imm 0x300.
  - Additionally, assert `RST` mid-stream and check all outputs are 0 next cycle.
